qupls_rat_cp: RTL and testbench
===============================

// Module: qupls_rat_cp
// PURPOSE
//  Parametrised checkpointed register alias table for the Q+ rename stage. It
//  maps NWR destinations and 3*NWR sources per cycle through the current
//  checkpoint map, and holds NCHKPT flop-based map snapshots for branch-miss
//  restore. Each mapping carries a ready bit updated by writeback, and each
//  write port returns the displaced physical reg so the ROB can free it at commit.
// PARAMETERS
//  AREGS   32  architectural registers; AB=$clog2(AREGS)
//  PREGS   64  physical registers; RB=$clog2(PREGS)
//  NCHKPT  8   checkpoints, power of 2; CB=$clog2(NCHKPT)
//  NWR     4   rename slots per group; NRD=3*NWR (localparam), SB=$clog2(NWR)
//  NWB     4   writeback ports
// PORTS
//  clk      in  1       clock, all state on posedge
//  rst      in  1       reset, asynchronous, active-low
//  en       in  1       rename group valid this cycle
//  stall_o  out 1       group refused (checkpoint table full)
//  wr       in  NWR     slot i writes a destination
//  wra      in  NWR*AB  dest arch reg per slot
//  wrp      in  NWR*RB  new phys reg per slot (from free list)
//  pold_o   out NWR*RB  phys reg displaced by slot i
//  rda      in  NRD*AB  source arch regs; port r belongs to slot r/3
//  rdp_o    out NRD*RB  source phys regs
//  rdv_o    out NRD     source ready
//  br       in  1       group holds a branch
//  br_slot  in  SB      slot of that branch
//  cp_o     out CB      checkpoint index assigned to the branch
//  restore  in  1       branch miss
//  miss_cp  in  CB      checkpoint to restore
//  cmt_br   in  1       oldest outstanding branch committed
//  wb_v     in  NWB     writeback valid
//  wb_p     in  NWB*RB  phys reg written back
//  cndx_o   out CB      current checkpoint index
//  nob_o    out CB+1    outstanding checkpoints
// BEHAVIOUR
//  Reset (rst=0, async): every checkpoint map[c][a]=a, rdy[c][a]=1; cndx=0,
//   ocp (oldest)=0; nob=0. Outputs are comb from state: stall_o=0, cndx_o=0, nob_o=0.
//  nob = (cndx-ocp) mod NCHKPT. Full when nob==NCHKPT-1.
//  stall_o = en & br & full (comb). Stalled group: no state change at all.
//  Reads (comb, 0 latency): rdp/rdv from map[cndx], bypassed from wr slots j <
//   the port's own slot; highest such j wins; bypassed rdv=0. Same-cycle wb
//   matching the phys reg forces rdv=1.
//  pold_o[i]: map[cndx][wra[i]] bypassed from slots j<i (same rule).
//  Commit (clocked, when en & ~stall_o & ~restore): map[cndx][wra[i]]<=wrp[i],
//   rdy<=0; same areg in two slots -> higher slot wins.
//  Branch: cp_o=cndx+1 (mod NCHKPT, comb). On accept, map[cndx+1] <= map[cndx]
//   updated by ALL slot writes; map[cndx] gets only writes from slots <= br_slot;
//   cndx<=cndx+1.
//  Writeback: every rdy[c][a] whose map entry == wb_p[k] & wb_v[k] -> 1, all
//   checkpoints. Same-cycle rename write to that entry wins (rdy=0).
//  cmt_br: ocp<=ocp+1 (mod). Ignored when nob==0. Not gated by stall/restore.
//  restore: cndx<=miss_cp; rename writes and branch ignored that cycle; later
//   checkpoints discarded via nob recompute. cmt_br same cycle still applies.
//   miss_cp outside [ocp,cndx] is a caller error; behaviour unspecified.
//  Wrap-around: cndx and ocp wrap mod NCHKPT; nob derived, never stored.
//  Reset mid-operation: all checkpoints return to identity, table empty.
// TESTING
//  Reset -> rdp(a)=a, rdv=1 for all a; cndx_o=0, nob_o=0, stall_o=0.
//  Slot0 wr r5->p40, slot2 reads r5 -> rdp=40, rdv=0; pold_o[0]=5; next cycle
//   wb p40 -> rdv=1.
//  Slots 1,3 both write r7 (p41,p42) -> map r7=p42; pold_o[3]=41.
//  br at slot1, slot0 wr r3->p50, slot2 wr r4->p51; then restore miss_cp=0 ->
//   r3=p50, r4=4, cndx_o=0.
//  Queue 7 branches (NCHKPT=8) -> nob_o=7; 8th br -> stall_o=1, no state change;
//   cmt_br -> nob_o=6, next br accepted, cndx_o wraps 7->0.
//  restore+cmt_br same cycle (ocp=2, cndx=5, miss_cp=4) -> cndx=4, ocp=3, nob_o=1.

Source files
------------

// File: rtl/qupls_rat_cp.sv
// qupls_rat_cp: checkpointed register alias table with per-mapping ready bits
module qupls_rat_cp #(
    parameter int AREGS  = 32,
    parameter int PREGS  = 64,
    parameter int NCHKPT = 8,
    parameter int NWR    = 4,
    parameter int NWB    = 4,
    localparam int AB    = $clog2(AREGS),
    localparam int RB    = $clog2(PREGS),
    localparam int CB    = $clog2(NCHKPT),
    localparam int SB    = $clog2(NWR),
    localparam int NRD   = 3 * NWR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              stall_o,
    input  logic [NWR-1:0]    wr,
    input  logic [NWR*AB-1:0] wra,
    input  logic [NWR*RB-1:0] wrp,
    output logic [NWR*RB-1:0] pold_o,
    input  logic [NRD*AB-1:0] rda,
    output logic [NRD*RB-1:0] rdp_o,
    output logic [NRD-1:0]    rdv_o,
    input  logic              br,
    input  logic [SB-1:0]     br_slot,
    output logic [CB-1:0]     cp_o,
    input  logic              restore,
    input  logic [CB-1:0]     miss_cp,
    input  logic              cmt_br,
    input  logic [NWB-1:0]    wb_v,
    input  logic [NWB*RB-1:0] wb_p,
    output logic [CB-1:0]     cndx_o,
    output logic [CB:0]       nob_o
);
    logic [RB-1:0]    map_q [NCHKPT][AREGS];
    logic [RB-1:0]    map_n [NCHKPT][AREGS];
    logic [AREGS-1:0] rdy_q [NCHKPT];
    logic [AREGS-1:0] rdy_n [NCHKPT];
    logic [CB-1:0]    cndx_q, ocp_q, cndx_n, ocp_n, nob, cp;
    logic             full, acc;

    assign nob     = cndx_q - ocp_q;
    assign full    = nob == CB'(NCHKPT - 1);
    assign stall_o = en & br & full;
    assign acc     = en & ~stall_o & ~restore;
    assign cp      = cndx_q + CB'(1);
    assign cp_o    = cp;
    assign cndx_o  = cndx_q;
    assign nob_o   = {1'b0, nob};

    // Source and displaced-register lookups through the live map, bypassed from earlier slots
    always_comb begin
        rdp_o  = '0;
        rdv_o  = '0;
        pold_o = '0;
        for (int r = 0; r < NRD; r++) begin
            rdp_o[r*RB +: RB] = map_q[cndx_q][rda[r*AB +: AB]];
            rdv_o[r] = rdy_q[cndx_q][rda[r*AB +: AB]];
            for (int j = 0; j < r / 3; j++)
                if (wr[j] && wra[j*AB +: AB] == rda[r*AB +: AB]) begin
                    rdp_o[r*RB +: RB] = wrp[j*RB +: RB];
                    rdv_o[r] = 1'b0;
                end
            for (int k = 0; k < NWB; k++)
                if (wb_v[k] && wb_p[k*RB +: RB] == rdp_o[r*RB +: RB])
                    rdv_o[r] = 1'b1;
        end
        for (int i = 0; i < NWR; i++) begin
            pold_o[i*RB +: RB] = map_q[cndx_q][wra[i*AB +: AB]];
            for (int j = 0; j < i; j++)
                if (wr[j] && wra[j*AB +: AB] == wra[i*AB +: AB])
                    pold_o[i*RB +: RB] = wrp[j*RB +: RB];
        end
    end

    // Next map/ready state: writeback first, then rename writes override, branch forks a checkpoint
    always_comb begin
        map_n = map_q;
        rdy_n = rdy_q;
        for (int c = 0; c < NCHKPT; c++)
            for (int a = 0; a < AREGS; a++)
                for (int k = 0; k < NWB; k++)
                    if (wb_v[k] && map_q[c][a] == wb_p[k*RB +: RB])
                        rdy_n[c][a] = 1'b1;
        if (acc) begin
            if (br) begin
                for (int a = 0; a < AREGS; a++)
                    map_n[cp][a] = map_q[cndx_q][a];
                rdy_n[cp] = rdy_n[cndx_q];
            end
            for (int i = 0; i < NWR; i++)
                if (wr[i]) begin
                    if (br) begin
                        map_n[cp][wra[i*AB +: AB]] = wrp[i*RB +: RB];
                        rdy_n[cp][wra[i*AB +: AB]] = 1'b0;
                    end
                    if (!br || SB'(i) <= br_slot) begin
                        map_n[cndx_q][wra[i*AB +: AB]] = wrp[i*RB +: RB];
                        rdy_n[cndx_q][wra[i*AB +: AB]] = 1'b0;
                    end
                end
        end
        cndx_n = restore ? miss_cp : (acc && br) ? cp : cndx_q;
        ocp_n  = (cmt_br && nob != '0) ? ocp_q + CB'(1) : ocp_q;
    end

    // State registers; reset returns every checkpoint to the identity map, all ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCHKPT; c++) begin
                for (int a = 0; a < AREGS; a++)
                    map_q[c][a] <= RB'(a);
                rdy_q[c] <= '1;
            end
            cndx_q <= '0;
            ocp_q  <= '0;
        end else begin
            map_q  <= map_n;
            rdy_q  <= rdy_n;
            cndx_q <= cndx_n;
            ocp_q  <= ocp_n;
        end
    end
endmodule

// File: tb/tb_qupls_rat_cp.sv
// tb_qupls_rat_cp: directed and randomized checks of the checkpointed rename table
module tb_qupls_rat_cp;
    localparam int AB = 5, RB = 6, CB = 3, NWR = 4, NRD = 12, NWB = 4, NC = 8, NA = 32;

    logic              clk = 0, rst = 1, en, br, restore, cmt_br, stall_o;
    logic [NWR-1:0]    wr;
    logic [NWR*AB-1:0] wra;
    logic [NWR*RB-1:0] wrp, pold_o;
    logic [NRD*AB-1:0] rda;
    logic [NRD*RB-1:0] rdp_o;
    logic [NRD-1:0]    rdv_o;
    logic [1:0]        br_slot;
    logic [CB-1:0]     cp_o, miss_cp, cndx_o;
    logic [NWB-1:0]    wb_v;
    logic [NWB*RB-1:0] wb_p;
    logic [CB:0]       nob_o;

    int checks = 0, errors = 0;
    int mm [NC][NA];
    bit mr [NC][NA];
    int mc, mo;

    qupls_rat_cp dut (
        .clk(clk), .rst(rst), .en(en), .stall_o(stall_o), .wr(wr), .wra(wra), .wrp(wrp),
        .pold_o(pold_o), .rda(rda), .rdp_o(rdp_o), .rdv_o(rdv_o), .br(br), .br_slot(br_slot),
        .cp_o(cp_o), .restore(restore), .miss_cp(miss_cp), .cmt_br(cmt_br), .wb_v(wb_v),
        .wb_p(wb_p), .cndx_o(cndx_o), .nob_o(nob_o)
    );

    always #5 clk = ~clk;

    task automatic idle;
        en = 0; br = 0; restore = 0; cmt_br = 0; wr = 0; wra = 0; wrp = 0; rda = 0;
        br_slot = 0; miss_cp = 0; wb_v = 0; wb_p = 0;
    endtask

    task automatic set_wr(input int i, input int a, input int p);
        wr[i] = 1'b1;
        wra[i*AB +: AB] = AB'(a);
        wrp[i*RB +: RB] = RB'(p);
    endtask

    task automatic model_reset;
        for (int c = 0; c < NC; c++)
            for (int a = 0; a < NA; a++) begin
                mm[c][a] = a;
                mr[c][a] = 1;
            end
        mc = 0;
        mo = 0;
    endtask

    function automatic int outstanding();
        return (mc - mo + NC) % NC;
    endfunction

    // Reference: apply one clock of the table's rules to the abstract maps
    task automatic model_step;
        int nm [NC][NA];
        bit nr [NC][NA];
        int nob, nxt, a;
        bit acc;
        nob = outstanding();
        acc = en && !restore && !(br && nob == NC - 1);
        nxt = (mc + 1) % NC;
        nm = mm;
        nr = mr;
        for (int c = 0; c < NC; c++)
            for (int x = 0; x < NA; x++)
                for (int k = 0; k < NWB; k++)
                    if (wb_v[k] && mm[c][x] == int'(wb_p[k*RB +: RB])) nr[c][x] = 1;
        if (acc) begin
            if (br)
                for (int x = 0; x < NA; x++) begin
                    nm[nxt][x] = mm[mc][x];
                    nr[nxt][x] = nr[mc][x];
                end
            for (int i = 0; i < NWR; i++)
                if (wr[i]) begin
                    a = int'(wra[i*AB +: AB]);
                    if (br) begin
                        nm[nxt][a] = int'(wrp[i*RB +: RB]);
                        nr[nxt][a] = 0;
                    end
                    if (!br || i <= int'(br_slot)) begin
                        nm[mc][a] = int'(wrp[i*RB +: RB]);
                        nr[mc][a] = 0;
                    end
                end
        end
        if (restore) mc = int'(miss_cp);
        else if (acc && br) mc = nxt;
        if (cmt_br && nob != 0) mo = (mo + 1) % NC;
        mm = nm;
        mr = nr;
    endtask

    task automatic exp_look(input int a, input int s, output int p, output bit v);
        p = mm[mc][a];
        v = mr[mc][a];
        for (int j = 0; j < s; j++)
            if (wr[j] && int'(wra[j*AB +: AB]) == a) begin
                p = int'(wrp[j*RB +: RB]);
                v = 0;
            end
        for (int k = 0; k < NWB; k++)
            if (wb_v[k] && int'(wb_p[k*RB +: RB]) == p) v = 1;
    endtask

    task automatic tick;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        #1;
    endtask

    task automatic test_reset;
        int a;
        idle();
        do_reset();
        en = 1; br = 1;
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < NRD; r++) rda[r*AB +: AB] = AB'((b * NRD + r) % NA);
            #1;
            for (int r = 0; r < NRD; r++) begin
                a = (b * NRD + r) % NA;
                checks++;
                if (rdp_o[r*RB +: RB] !== RB'(a) || rdv_o[r] !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_map r%0d: got p%0d rdy=%b expected p%0d rdy=1", a, rdp_o[r*RB +: RB], rdv_o[r], a);
                end
            end
        end
        checks++;
        if (cndx_o !== 3'd0 || nob_o !== 4'd0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got cndx=%0d nob=%0d stall=%b expected 0 0 0", cndx_o, nob_o, stall_o);
        end
        idle();
    endtask

    task automatic test_bypass;
        idle();
        en = 1;
        set_wr(0, 5, 40);
        rda[6*AB +: AB] = 5;
        #1;
        checks++;
        if (rdp_o[6*RB +: RB] !== 6'd40 || rdv_o[6] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_read: got p%0d rdy=%b expected p40 rdy=0", rdp_o[6*RB +: RB], rdv_o[6]);
        end
        checks++;
        if (pold_o[0 +: RB] !== 6'd5) begin
            errors++;
            $display("FAIL bypass_pold0: got %0d expected 5", pold_o[0 +: RB]);
        end
        tick();
        idle();
        rda[0 +: AB] = 5;
        #1;
        checks++;
        if (rdp_o[0 +: RB] !== 6'd40 || rdv_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_committed: got p%0d rdy=%b expected p40 rdy=0", rdp_o[0 +: RB], rdv_o[0]);
        end
        wb_v[2] = 1;
        wb_p[2*RB +: RB] = 40;
        #1;
        checks++;
        if (rdv_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL wb_forward: got rdy=%b expected 1", rdv_o[0]);
        end
        tick();
        wb_v = 0;
        #1;
        checks++;
        if (rdv_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL wb_stored: got rdy=%b expected 1", rdv_o[0]);
        end
        idle();
    endtask

    task automatic test_same_areg;
        idle();
        en = 1;
        set_wr(1, 7, 41);
        set_wr(3, 7, 42);
        #1;
        checks++;
        if (pold_o[3*RB +: RB] !== 6'd41 || pold_o[1*RB +: RB] !== 6'd7) begin
            errors++;
            $display("FAIL same_areg_pold: got %0d/%0d expected 7/41", pold_o[1*RB +: RB], pold_o[3*RB +: RB]);
        end
        tick();
        idle();
        rda[0 +: AB] = 7;
        #1;
        checks++;
        if (rdp_o[0 +: RB] !== 6'd42) begin
            errors++;
            $display("FAIL same_areg_map: got p%0d expected p42", rdp_o[0 +: RB]);
        end
    endtask

    task automatic test_branch_restore;
        idle();
        en = 1; br = 1; br_slot = 1;
        set_wr(0, 3, 50);
        set_wr(2, 4, 51);
        #1;
        checks++;
        if (cp_o !== 3'd1 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL branch_cp: got cp=%0d stall=%b expected 1 0", cp_o, stall_o);
        end
        tick();
        idle();
        rda[0 +: AB] = 3;
        rda[AB +: AB] = 4;
        #1;
        checks++;
        if (cndx_o !== 3'd1 || rdp_o[0 +: RB] !== 6'd50 || rdp_o[RB +: RB] !== 6'd51) begin
            errors++;
            $display("FAIL branch_fork: got cndx=%0d r3=p%0d r4=p%0d expected 1 p50 p51", cndx_o, rdp_o[0 +: RB], rdp_o[RB +: RB]);
        end
        restore = 1;
        miss_cp = 0;
        tick();
        restore = 0;
        #1;
        checks++;
        if (cndx_o !== 3'd0 || nob_o !== 4'd0 || rdp_o[0 +: RB] !== 6'd50 || rdp_o[RB +: RB] !== 6'd4) begin
            errors++;
            $display("FAIL restore_map: got cndx=%0d nob=%0d r3=p%0d r4=p%0d expected 0 0 p50 p4", cndx_o, nob_o, rdp_o[0 +: RB], rdp_o[RB +: RB]);
        end
        idle();
    endtask

    task automatic test_full_wrap;
        idle();
        for (int n = 0; n < 7; n++) begin
            en = 1; br = 1;
            tick();
        end
        checks++;
        if (nob_o !== 4'd7 || cndx_o !== 3'd7) begin
            errors++;
            $display("FAIL full_count: got nob=%0d cndx=%0d expected 7 7", nob_o, cndx_o);
        end
        set_wr(0, 9, 60);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: got stall=%b expected 1", stall_o);
        end
        tick();
        idle();
        rda[0 +: AB] = 9;
        #1;
        checks++;
        if (nob_o !== 4'd7 || cndx_o !== 3'd7 || rdp_o[0 +: RB] !== 6'd9 || rdv_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_frozen: got nob=%0d cndx=%0d r9=p%0d rdy=%b expected 7 7 p9 1", nob_o, cndx_o, rdp_o[0 +: RB], rdv_o[0]);
        end
        cmt_br = 1;
        tick();
        idle();
        #1;
        checks++;
        if (nob_o !== 4'd6) begin
            errors++;
            $display("FAIL cmt_nob: got %0d expected 6", nob_o);
        end
        en = 1; br = 1;
        #1;
        checks++;
        if (stall_o !== 1'b0 || cp_o !== 3'd0) begin
            errors++;
            $display("FAIL wrap_cp: got stall=%b cp=%0d expected 0 0", stall_o, cp_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (cndx_o !== 3'd0 || nob_o !== 4'd7) begin
            errors++;
            $display("FAIL wrap_cndx: got cndx=%0d nob=%0d expected 0 7", cndx_o, nob_o);
        end
    endtask

    task automatic test_restore_cmt;
        idle();
        en = 1;
        set_wr(0, 3, 33);
        tick();
        idle();
        do_reset();
        for (int n = 0; n < 5; n++) begin
            en = 1; br = 1;
            tick();
        end
        idle();
        cmt_br = 1;
        tick();
        tick();
        idle();
        #1;
        checks++;
        if (cndx_o !== 3'd5 || nob_o !== 4'd3) begin
            errors++;
            $display("FAIL restore_cmt_setup: got cndx=%0d nob=%0d expected 5 3", cndx_o, nob_o);
        end
        restore = 1; miss_cp = 4; cmt_br = 1;
        tick();
        idle();
        rda[0 +: AB] = 3;
        #1;
        checks++;
        if (cndx_o !== 3'd4 || nob_o !== 4'd1 || rdp_o[0 +: RB] !== 6'd3) begin
            errors++;
            $display("FAIL restore_cmt: got cndx=%0d nob=%0d r3=p%0d expected 4 1 p3", cndx_o, nob_o, rdp_o[0 +: RB]);
        end
    endtask

    task automatic test_random;
        int p, nob;
        bit v;
        for (int n = 0; n < 600; n++) begin
            idle();
            en = $urandom_range(0, 3) != 0;
            br = $urandom_range(0, 2) == 0;
            br_slot = 2'($urandom);
            cmt_br = $urandom_range(0, 3) == 0;
            restore = $urandom_range(0, 9) == 0;
            nob = outstanding();
            miss_cp = 3'((mo + $urandom_range(0, nob)) % NC);
            for (int i = 0; i < NWR; i++)
                if ($urandom_range(0, 1) != 0) set_wr(i, $urandom_range(0, 11), $urandom_range(0, 63));
            for (int r = 0; r < NRD; r++) rda[r*AB +: AB] = AB'($urandom_range(0, 11));
            for (int k = 0; k < NWB; k++) begin
                wb_v[k] = $urandom_range(0, 2) == 0;
                wb_p[k*RB +: RB] = RB'(mm[$urandom_range(0, NC - 1)][$urandom_range(0, 11)]);
            end
            #1;
            checks++;
            if (stall_o !== (en && br && nob == NC - 1) || cp_o !== 3'((mc + 1) % NC) ||
                cndx_o !== 3'(mc) || nob_o !== 4'(nob)) begin
                errors++;
                $display("FAIL rand_ctl cycle %0d: got stall=%b cp=%0d cndx=%0d nob=%0d expected cndx=%0d nob=%0d",
                         n, stall_o, cp_o, cndx_o, nob_o, mc, nob);
            end
            for (int r = 0; r < NRD; r++) begin
                exp_look(int'(rda[r*AB +: AB]), r / 3, p, v);
                checks++;
                if (rdp_o[r*RB +: RB] !== RB'(p) || rdv_o[r] !== v) begin
                    errors++;
                    $display("FAIL rand_read cycle %0d port %0d: got p%0d rdy=%b expected p%0d rdy=%b",
                             n, r, rdp_o[r*RB +: RB], rdv_o[r], p, v);
                end
            end
            for (int i = 0; i < NWR; i++) begin
                exp_look(int'(wra[i*AB +: AB]), i, p, v);
                p = mm[mc][int'(wra[i*AB +: AB])];
                for (int j = 0; j < i; j++)
                    if (wr[j] && wra[j*AB +: AB] == wra[i*AB +: AB]) p = int'(wrp[j*RB +: RB]);
                checks++;
                if (pold_o[i*RB +: RB] !== RB'(p)) begin
                    errors++;
                    $display("FAIL rand_pold cycle %0d slot %0d: got p%0d expected p%0d", n, i, pold_o[i*RB +: RB], p);
                end
            end
            if ($urandom_range(0, 149) == 0) do_reset();
            else tick();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_bypass();
        test_same_areg();
        test_branch_restore();
        test_full_wrap();
        test_restore_cmt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
